uart_rx_module: RTL
===================

# uart_rx_module

UART receive engine for the 50 MHz demo boards: the receive-side counterpart of the UART TX path and its 1 s transmit controller. It oversamples the serial input with a baud-rate counter and deserialises 8N1 frames, LSB first. Each good byte is reported with a one-cycle done pulse; bad frames get a one-cycle error pulse. It sits between the board RX pin and an RX control module that consumes bytes.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- Derived localparam BIT_CYC = CLK_FREQ/BAUD (5208 at the defaults). HALF_BIT = BIT_CYC/2 (2604). Counter width is $clog2(BIT_CYC).

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- RX_Pin_In  in  1  asynchronous serial line; idles high
- RX_En_Sig  in  1  receive enable, level
- RX_Done_Sig  out  1  one-cycle pulse when a good byte has been received
- RX_Err_Sig  out  1  one-cycle pulse on a framing error (stop bit = 0)
- RX_Data  out  8  last good byte; held until the next good frame

## Operation
- RX_Pin_In passes through a 2-FF synchroniser (reset value 1), then a falling-edge detector (previous sample reset value 1).
- States: IDLE, START, DATA, STOP, DONE.
- IDLE: a falling edge with RX_En_Sig=1 moves to START and clears the counter. All other input is ignored.
- START: count HALF_BIT cycles, then sample the line.
  - Sample 0: go to DATA.
  - Sample 1: glitch; go to IDLE with no pulse.
- DATA: count BIT_CYC cycles per bit and sample on the last count. Shift the sample into a shift register LSB-first. After 8 bits, go to STOP.
- STOP: count BIT_CYC cycles and sample.
  - Sample 1: load RX_Data from the shift register, pulse RX_Done_Sig, go to DONE.
  - Sample 0: pulse RX_Err_Sig, leave RX_Data unchanged, go to DONE.
- DONE: one cycle, then IDLE.
- RX_En_Sig=0 in any state other than IDLE aborts to IDLE on the next edge. No pulse is produced and RX_Data is unchanged.
- Line stuck low (break): no retrigger, because a new frame needs a new falling edge.
- Reset mid-frame: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values: RX_Done_Sig=0, RX_Err_Sig=0, RX_Data=8'h00, state IDLE, counter 0, shift register 0.
- Pin-to-edge latency: 3 cycles (2 synchroniser stages plus edge register).
- Cycle 0 is the first cycle in START. Relative to cycle 0:
  - start bit sampled at cycle HALF_BIT-1;
  - data bit k (k=0..7) sampled at cycle HALF_BIT-1+(k+1)·BIT_CYC;
  - stop bit sampled at cycle HALF_BIT-1+9·BIT_CYC.
- RX_Done_Sig / RX_Err_Sig go high the cycle after the stop sample, for exactly one cycle. RX_Data is valid in that same cycle.
- Done and error are mutually exclusive.
- Back-to-back frames with no idle gap are received: the next start edge arrives HALF_BIT cycles after the stop sample, and IDLE is re-entered 2 cycles after it.

## Configuration
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, stop) is the 2-of-3 majority of the synchronised line at nominal sample cycle -2, -1 and 0. A single-cycle glitch at the sample point is rejected. Sample timing and output timing are unchanged.
- Undefined: a single sample at the nominal cycle.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, DONE);
  - DEFAULT_CLK_FREQ and DEFAULT_BAUD;
  - the data width constant (8). The TX side uses the same package.
- Sub-module rx_bps_module holds the baud counter.
  - Inputs: count enable and clear.
  - Outputs: half-bit strobe and full-bit strobe.
  - The FSM, synchroniser and shift register stay in uart_rx_module.

## Test plan
- Reset asserted mid-frame -> all outputs 0 and state IDLE immediately; the next clean frame 0x31 is received normally.
- Frame 0x31 at 9600 baud, RX_En_Sig=1 -> one RX_Done_Sig pulse at the cycle given in Timing, RX_Data=8'h31, RX_Err_Sig stays 0.
- Low glitch of 1000 cycles (< HALF_BIT) -> no pulses, back in IDLE; a following frame 0xA5 gives RX_Data=8'hA5.
- Frame 0x55 with stop bit 0 -> one RX_Err_Sig pulse, no RX_Done_Sig, RX_Data keeps 8'h31; a following held-low break gives no further pulses.
- RX_En_Sig dropped during data bit 3 of 0x7E -> no pulse, RX_Data unchanged; re-enabled, the frame 0x7E is received correctly.
- Back-to-back 0x00 then 0xFF with no gap -> two done pulses with RX_Data 0x00 then 0xFF.
  - With UART_RX_MAJORITY_EN: 1-cycle inverted glitches placed at each sample point of 0xFF give RX_Data=8'hFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX engine and the TX path:
// frame state encoding, default clock/baud settings and the data width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } uart_state_e;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int DATA_W           = 8;

endpackage

// File: rtl/uart_rx_module_if.sv
// Byte-level signal bundle between the board RX pin, the receive engine
// (slave) and the RX control logic that drives enable and consumes bytes (master).
interface uart_rx_module_if;
  import uart_pkg::*;

  logic              RX_Pin_In;
  logic              RX_En_Sig;
  logic              RX_Done_Sig;
  logic              RX_Err_Sig;
  logic [DATA_W-1:0] RX_Data;

  modport master (
    output RX_Pin_In,
    output RX_En_Sig,
    input  RX_Done_Sig,
    input  RX_Err_Sig,
    input  RX_Data
  );

  modport slave (
    input  RX_Pin_In,
    input  RX_En_Sig,
    output RX_Done_Sig,
    output RX_Err_Sig,
    output RX_Data
  );

endinterface

// File: rtl/rx_bps_module.sv
// Baud-rate counter for the UART receiver: free-runs over one bit period while
// enabled and flags the half-bit and last-count cycles.
module rx_bps_module
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic cnt_en_i,
  input  logic cnt_clr_i,
  output logic half_stb_o,
  output logic full_stb_o
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_BIT = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrapping at the full-bit count lets consecutive data bits run without a clear.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = (cnt_q == FULL_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_stb_o = cnt_en_i && (cnt_q == HALF_LAST);
  assign full_stb_o = cnt_en_i && (cnt_q == FULL_LAST);

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receive engine with done/error pulses. Define UART_RX_MAJORITY_EN
// to take each bit as the 2-of-3 vote of the last three synchronised samples.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic            CLK,
  input  logic            RSTn,
  uart_rx_module_if.slave rx_if
);

  logic              sync1_q, sync2_q, prev_q;
  logic              fall_edge, bit_val;
  logic              half_stb, full_stb, cnt_en, cnt_clr;
  uart_state_e       state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Line idles high, so synchroniser and edge history reset to 1.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_if.RX_Pin_In;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_edge = prev_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic prev2_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev2_q <= 1'b1;
    end else begin
      prev2_q <= prev_q;
    end
  end

  assign bit_val = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);
`else
  assign bit_val = sync2_q;
`endif

  rx_bps_module #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_bps (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .cnt_en_i   (cnt_en),
    .cnt_clr_i  (cnt_clr),
    .half_stb_o (half_stb),
    .full_stb_o (full_stb)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_edge && rx_if.RX_En_Sig) begin
          state_d = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        cnt_en = 1'b1;
        // Re-centre the counter so data samples land mid-bit.
        if (half_stb) begin
          cnt_clr   = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_en = 1'b1;
        if (full_stb) begin
          shift_d   = {bit_val, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        if (full_stb) begin
          state_d = DONE;
          if (bit_val) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE && !rx_if.RX_En_Sig) begin
      state_d = IDLE;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_en  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rx_if.RX_Done_Sig = done_q;
  assign rx_if.RX_Err_Sig  = err_q;
  assign rx_if.RX_Data     = data_q;

endmodule
